dct_transpose_buf: RTL and testbench

- Ping-pong 8x8 transpose buffer between the row-pass and column-pass dct1d stages of the 2D DCT.
- Row-pass results arrive one 8-coefficient row per transfer. The buffer holds one block per bank and replays each block column-by-column, 8 coefficients per transfer, to the column pass.
- Two banks allow block k+1 to be written while block k is read.

---
 rtl/dct_pkg.sv | 22 ++
 rtl/dct_tbuf_bank.sv | 47 ++++
 rtl/dct_transpose_buf.sv | 124 ++++++++++++
 tb/tb_dct_transpose_buf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// ============================================================================
// dct_pkg : shared DCT constants, coefficient type and 8-lane bus packing
// Revision: 1.0
// ============================================================================
`default_nettype none

package dct_pkg;

  localparam int DCT_N     = 8;
  localparam int DCT_IDX_W = 3;
  localparam int DCT_W     = 16;

  typedef logic signed [DCT_W-1:0] coef_t;

  // Lane k of an 8-lane bus occupies bits [k*w +: w].
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dct_tbuf_bank.sv
// ============================================================================
// dct_tbuf_bank : 8x8 coefficient array, row-write port and column-read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module dct_tbuf_bank
  import dct_pkg::*;
#(
  parameter int W = 16,
  parameter int N = DCT_N
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DCT_IDX_W-1:0] wr_row,
  input  logic [N*W-1:0]       wr_data,
  input  logic [DCT_IDX_W-1:0] rd_col,
  output logic [N*W-1:0]       rd_data
);

  // Storage is intentionally not reset; validity is tracked by the owner.
  logic [W-1:0] mem_q [N][N];
  logic [W-1:0] mem_d [N][N];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int c = 0; c < N; c++) begin
        mem_d[wr_row][c] = wr_data[lane_lsb(c, W) +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N; r++) begin
      rd_data[lane_lsb(r, W) +: W] = mem_q[r][rd_col];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dct_transpose_buf.sv
// ============================================================================
// dct_transpose_buf : ping-pong 8x8 transpose buffer between DCT row/col passes
// Revision: 1.0
// ============================================================================
`default_nettype none

module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_col,
  output logic           out_last,
  output logic           blk_done
);

  generate
    if (N != DCT_N) begin : g_bad_n
      $error("dct_transpose_buf: N must be 8");
    end
  endgenerate

  localparam logic [DCT_IDX_W-1:0] LAST_IDX = DCT_IDX_W'(DCT_N - 1);

  logic                 wr_bank_q, wr_bank_d;
  logic [DCT_IDX_W-1:0] wr_row_q,  wr_row_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [DCT_IDX_W-1:0] rd_col_q,  rd_col_d;
  logic [1:0]           full_q,    full_d;
  logic                 blk_done_q, blk_done_d;

  logic           in_fire;
  logic           out_fire;
  logic           set_full;
  logic           clr_full;
  logic [N*W-1:0] bank_rd [2];

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign set_full  = in_fire && (wr_row_q == LAST_IDX);
  assign clr_full  = out_fire && (rd_col_q == LAST_IDX);

  assign out_col   = out_valid ? bank_rd[rd_bank_q] : '0;
  assign out_last  = out_valid && (rd_col_q == LAST_IDX);
  assign blk_done  = blk_done_q;

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      dct_tbuf_bank #(
        .W (W),
        .N (N)
      ) u_bank (
        .clk     (clk),
        .we      (in_fire && (wr_bank_q == 1'(b))),
        .wr_row  (wr_row_q),
        .wr_data (in_row),
        .rd_col  (rd_col_q),
        .rd_data (bank_rd[b])
      );
    end
  endgenerate

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_row_d   = wr_row_q;
    rd_bank_d  = rd_bank_q;
    rd_col_d   = rd_col_q;
    full_d     = full_q;
    blk_done_d = clr_full;

    if (in_fire) begin
      wr_row_d = wr_row_q + 1'b1;
    end
    if (set_full) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end

    if (out_fire) begin
      rd_col_d = rd_col_q + 1'b1;
    end
    // Banks alternate, so set and clear never target the same flag.
    if (clr_full) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_col_q   <= '0;
      full_q     <= '0;
      blk_done_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_row_q   <= wr_row_d;
      rd_bank_q  <= rd_bank_d;
      rd_col_q   <= rd_col_d;
      full_q     <= full_d;
      blk_done_q <= blk_done_d;
    end
  end

  a_no_set_clr_same_bank: assert property (
    @(posedge clk) disable iff (reset)
      !(set_full && clr_full && (wr_bank_q == rd_bank_q))
  );

endmodule

`default_nettype wire

// File: tb/tb_dct_transpose_buf.sv
// ============================================================================
// tb_dct_transpose_buf : transpose buffer bench against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dct_transpose_buf;

  localparam int W = 16;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] in_row = '0;
  logic           in_ready;
  logic           out_valid;
  logic [N*W-1:0] out_col;
  logic           out_last;
  logic           blk_done;

  always #5 clk = ~clk;

  dct_transpose_buf #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last),
    .blk_done  (blk_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: rows of the block being assembled, and rows of complete
  // blocks awaiting readout (8 rows per block, oldest first).
  logic [N*W-1:0] part_q[$];
  logic [N*W-1:0] blk_q[$];
  int  exp_col  = 0;
  bit  exp_done = 1'b0;
  bit  in_acc   = 1'b0;

  always @(negedge clk) begin
    bit             exp_ready;
    bit             exp_valid;
    logic [N*W-1:0] e;
    logic [N*W-1:0] row;
    if (reset) begin
      part_q.delete();
      blk_q.delete();
      exp_col  = 0;
      exp_done = 1'b0;
    end
    exp_ready = (blk_q.size() / N) < 2;
    exp_valid = blk_q.size() > 0;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      e = '0;
      for (int r = 0; r < N; r++) begin
        row = blk_q[r];
        e[r*W +: W] = row[exp_col*W +: W];
      end
      check("out_col", out_col, e);
      check("out_last", out_last, exp_col == N - 1);
    end else begin
      check("out_col_zero", out_col, '0);
      check("out_last_idle", out_last, 1'b0);
    end
    check("blk_done", blk_done, exp_done);
    exp_done = 1'b0;

    in_acc = !reset && in_valid && exp_ready;
    if (in_acc) begin
      part_q.push_back(in_row);
      if (part_q.size() == N) begin
        for (int r = 0; r < N; r++) blk_q.push_back(part_q[r]);
        part_q.delete();
      end
    end
    if (!reset && exp_valid && out_ready) begin
      if (exp_col == N - 1) begin
        exp_col  = 0;
        exp_done = 1'b1;
        for (int r = 0; r < N; r++) void'(blk_q.pop_front());
      end else begin
        exp_col++;
      end
    end
  end

  // Stimulus state
  int             rows_left = 0;
  int             gen_blk   = 0;
  int             gen_row   = 0;
  bit             rnd_data  = 1'b0;
  bit             rnd_valid = 1'b0;
  int             rdy_mode  = 1;   // 0 low, 1 high, 2 random
  logic [N*W-1:0] cur_row   = '0;

  function automatic logic [N*W-1:0] make_row(input int b, input int r, input bit rnd);
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) begin
      v[c*W +: W] = rnd ? W'($urandom) : W'(256*b + 16*r + c);
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (in_acc) begin
      rows_left--;
      gen_row++;
      if (gen_row == N) begin
        gen_row = 0;
        gen_blk++;
      end
      cur_row = make_row(gen_blk, gen_row, rnd_data);
    end
    in_valid  = (rows_left > 0) && (!rnd_valid || ($urandom_range(0, 1) == 1));
    in_row    = cur_row;
    out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  endtask

  task automatic start_rows(input int n, input bit rnd);
    rows_left = n;
    rnd_data  = rnd;
    cur_row   = make_row(gen_blk, gen_row, rnd);
  endtask

  task automatic send(input int budget);
    int b = budget;
    while (rows_left > 0 && b > 0) begin
      step();
      b--;
    end
    check("send_budget", rows_left, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_col", out_col, '0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_blk_done", blk_done, 1'b0);
    rows_left = 0;
    gen_row   = 0;
    gen_blk++;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single block
    rdy_mode = 1;
    start_rows(8, 1'b0);
    send(100);
    idle(12);

    // Three blocks back-to-back
    start_rows(24, 1'b0);
    send(100);
    idle(12);

    // Backpressure: fill both banks, hold a 17th row, then release
    rdy_mode = 0;
    start_rows(24, 1'b0);
    repeat (20) step();
    rdy_mode = 1;
    send(200);
    idle(20);

    // Reset after 5 rows of a block, then a fresh block
    start_rows(5, 1'b0);
    send(100);
    do_reset();
    start_rows(8, 1'b0);
    send(100);
    idle(12);

    // Reset with both banks full while column 3 is presented
    rdy_mode = 0;
    start_rows(16, 1'b0);
    send(100);
    rdy_mode = 1;
    repeat (3) step();
    do_reset();
    idle(10);
    start_rows(8, 1'b0);
    send(100);
    idle(12);

    // Random valid/ready over 20 blocks of random data
    rnd_valid = 1'b1;
    rdy_mode  = 2;
    start_rows(160, 1'b1);
    send(3000);
    rnd_valid = 1'b0;
    rdy_mode  = 1;
    idle(30);

    check("final_empty", blk_q.size(), 0);
    check("final_partial", part_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
